// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_types_pkg
//  Description : Shared CPU types: memory word, RAM status and the memory
//                arbiter state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

  // One 32-bit memory word (addresses and data).
  typedef logic [31:0] word_t;

  // Status reported by the RAM model each cycle.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Memory arbiter grant state.
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_IFETCH = 2'd1,
    ARB_DREAD  = 2'd2,
    ARB_DWRITE = 2'd3
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : memory_arbiter
//  Description : Arbitrates a single-ported RAM between the icache (reads)
//                and the dcache (reads/writes). Data accesses have priority,
//                but a saturating counter forces an icache grant after
//                STARVE_LIMIT consecutive dcache completions while iREN waits.
//  Ports       : CLK, nRST          - clock, async active-low reset
//                iREN/iaddr         - icache read request and address
//                iwait/iload        - icache handshake and read data
//                dREN/dWEN          - dcache read / write requests
//                daddr/dstore       - dcache address and write data
//                dwait/dload        - dcache handshake and read data
//                ramREN/ramWEN      - RAM enables
//                ramaddr/ramstore   - RAM address and write data
//                ramload/ramstate   - RAM read data and status
//  Revision    : 1.0 - initial release
// ============================================================================
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic      CLK,
  input  logic      nRST,
  // icache side
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  // dcache side
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  // RAM side
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate
);

  arb_state_t state_q, state_d;
  logic [2:0] starve_cnt_q, starve_cnt_d;

  logic w_req;      // the granted requester is still asking
  logic w_done;     // the granted access completes this cycle
  logic w_starve;

  assign w_starve = ({29'd0, starve_cnt_q} >= STARVE_LIMIT);

  // RAM drive and handshake outputs depend only on the current grant, so an
  // asynchronous reset of state_q drops the enables immediately.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    w_req    = 1'b0;
    case (state_q)
      ARB_IFETCH: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        w_req   = iREN;
      end
      ARB_DREAD: begin
        ramREN  = 1'b1;
        ramaddr = daddr;
        w_req   = dREN;
      end
      ARB_DWRITE: begin
        ramWEN   = 1'b1;
        ramaddr  = daddr;
        ramstore = dstore;
        w_req    = dWEN;
      end
      default: ;
    endcase
    // A dropped request aborts the grant, so it never signals completion.
    w_done = (state_q != ARB_IDLE) && w_req && (ramstate == ACCESS);
    if (w_done) begin
      if (state_q == ARB_IFETCH) begin
        iwait = 1'b0;
        iload = ramload;
      end else begin
        dwait = 1'b0;
        if (state_q == ARB_DREAD) dload = ramload;
      end
    end
  end

  // Next grant and starvation bookkeeping.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;

    if (state_q == ARB_IDLE) begin
      if (w_starve && iREN) state_d = ARB_IFETCH;
      else if (dWEN)        state_d = ARB_DWRITE;
      else if (dREN)        state_d = ARB_DREAD;
      else if (iREN)        state_d = ARB_IFETCH;
    end else if (!w_req || ramstate == ACCESS || ramstate == ERROR) begin
      // Completion, retry-on-error and abort all go back through IDLE.
      state_d = ARB_IDLE;
    end

    if (!iREN) begin
      starve_cnt_d = 3'd0;
    end else if (w_done && state_q == ARB_IFETCH) begin
      starve_cnt_d = 3'd0;
    end else if (w_done && starve_cnt_q != 3'd7) begin
      starve_cnt_d = starve_cnt_q + 3'd1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= ARB_IDLE;
      starve_cnt_q <= 3'd0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memory_arbiter
//  Description : Self-checking bench for memory_arbiter: directed scenarios
//                plus randomized traffic against a transaction-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  localparam int LIMIT = 4;

  logic      CLK, nRST;
  logic      iREN, dREN, dWEN;
  word_t     iaddr, daddr, dstore, ramload;
  ramstate_t ramstate;
  logic      iwait, dwait, ramREN, ramWEN;
  word_t     iload, dload, ramaddr, ramstore;

  int asserts  = 0;
  int failures = 0;

  memory_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: who owns the RAM (0 none, 1 icache, 2 dcache read,
  // 3 dcache write) and how many dcache completions the waiting icache saw.
  int    owner = 0;
  int    dwins = 0;
  logic  e_ren, e_wen, e_iwait, e_dwait, e_done;
  word_t e_addr, e_store, e_iload, e_dload;

  task automatic model_eval();
    bit still;
    still   = (owner == 1 && iREN) || (owner == 2 && dREN) || (owner == 3 && dWEN);
    e_done  = still && (ramstate == ACCESS);
    e_ren   = (owner == 1 || owner == 2);
    e_wen   = (owner == 3);
    e_addr  = (owner == 1) ? iaddr : (owner >= 2) ? daddr : 32'h0;
    e_store = (owner == 3) ? dstore : 32'h0;
    e_iwait = !(e_done && owner == 1);
    e_dwait = !(e_done && owner >= 2);
    e_iload = e_iwait ? 32'h0 : ramload;
    e_dload = (!e_dwait && owner == 2) ? ramload : 32'h0;
  endtask

  // Advance one clock, moving the model by the same rules.
  task automatic tick();
    int    n_owner, n_dwins;
    bit    still;
    model_eval();
    still   = (owner == 1 && iREN) || (owner == 2 && dREN) || (owner == 3 && dWEN);
    n_owner = owner;
    n_dwins = dwins;
    if (owner == 0) begin
      if (dwins >= LIMIT && iREN) n_owner = 1;
      else if (dWEN)              n_owner = 3;
      else if (dREN)              n_owner = 2;
      else if (iREN)              n_owner = 1;
    end else if (!still || ramstate == ACCESS || ramstate == ERROR) begin
      n_owner = 0;
    end
    if (!iREN)                     n_dwins = 0;
    else if (e_done && owner == 1) n_dwins = 0;
    else if (e_done)               n_dwins = (dwins < 7) ? dwins + 1 : 7;
    @(posedge CLK);
    #1;
    if (!nRST) begin
      owner = 0;
      dwins = 0;
    end else begin
      owner = n_owner;
      dwins = n_dwins;
    end
  endtask

  task automatic idle_inputs();
    iREN = 0; dREN = 0; dWEN = 0; ramstate = FREE;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0;
  endtask

  task automatic test_reset();
    nRST = 0;
    iREN = 1; dREN = 1; dWEN = 1; ramstate = ACCESS;
    iaddr = 32'h11; daddr = 32'h22; dstore = 32'h33; ramload = 32'h44;
    #1;
    asserts++; if ({ramREN, ramWEN} !== 2'b00) begin failures++; $display("FAIL reset_en: got %b required 00", {ramREN, ramWEN}); end
    asserts++; if ({iwait, dwait} !== 2'b11) begin failures++; $display("FAIL reset_wait: got %b required 11", {iwait, dwait}); end
    asserts++; if (ramaddr !== 32'h0 || ramstore !== 32'h0) begin failures++; $display("FAIL reset_bus: got addr %h store %h required 0", ramaddr, ramstore); end
    asserts++; if (iload !== 32'h0 || dload !== 32'h0) begin failures++; $display("FAIL reset_load: got %h %h required 0", iload, dload); end
    tick();
    asserts++; if ({ramREN, ramWEN} !== 2'b00) begin failures++; $display("FAIL reset_held: got %b required 00", {ramREN, ramWEN}); end
    idle_inputs();
    nRST = 1;
    tick();
  endtask

  task automatic test_ifetch();
    iREN = 1; iaddr = 32'h40; ramstate = BUSY; #1;
    asserts++; if (ramREN !== 1'b0) begin failures++; $display("FAIL if_idle_ren: got %b required 0", ramREN); end
    tick(); // IFETCH, busy 1
    asserts++; if (ramREN !== 1'b1 || ramaddr !== 32'h40) begin failures++; $display("FAIL if_grant: got ren %b addr %h required 1 00000040", ramREN, ramaddr); end
    asserts++; if (iwait !== 1'b1) begin failures++; $display("FAIL if_busy1_wait: got %b required 1", iwait); end
    tick(); // busy 2
    asserts++; if (iwait !== 1'b1 || ramREN !== 1'b1) begin failures++; $display("FAIL if_busy2: got wait %b ren %b required 1 1", iwait, ramREN); end
    ramstate = ACCESS; ramload = 32'hDEADBEEF; #1;
    asserts++; if (iwait !== 1'b0 || iload !== 32'hDEADBEEF) begin failures++; $display("FAIL if_done: got wait %b load %h required 0 deadbeef", iwait, iload); end
    asserts++; if (dwait !== 1'b1 || dload !== 32'h0) begin failures++; $display("FAIL if_dside: got dwait %b dload %h required 1 0", dwait, dload); end
    tick();
    idle_inputs(); #1;
    asserts++; if (iwait !== 1'b1 || ramREN !== 1'b0 || iload !== 32'h0) begin failures++; $display("FAIL if_after: got wait %b ren %b load %h required 1 0 0", iwait, ramREN, iload); end
    tick();
  endtask

  task automatic test_priority();
    iREN = 1; dREN = 1; dWEN = 1; iaddr = 32'h9C;
    daddr = 32'h80; dstore = 32'h12345678; ramstate = BUSY;
    tick();
    asserts++; if (ramWEN !== 1'b1 || ramREN !== 1'b0) begin failures++; $display("FAIL pri_enables: got wen %b ren %b required 1 0", ramWEN, ramREN); end
    asserts++; if (ramaddr !== 32'h80 || ramstore !== 32'h12345678) begin failures++; $display("FAIL pri_bus: got addr %h store %h required 00000080 12345678", ramaddr, ramstore); end
    ramstate = ACCESS; ramload = 32'hCAFE0001; #1;
    asserts++; if (dwait !== 1'b0 || iwait !== 1'b1 || dload !== 32'h0) begin failures++; $display("FAIL pri_done: got dwait %b iwait %b dload %h required 0 1 0", dwait, iwait, dload); end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_starvation();
    word_t exp_addr;
    iREN = 1; dREN = 1; dWEN = 0; iaddr = 32'h100; daddr = 32'h200;
    ramstate = ACCESS; ramload = 32'h5A5A5A5A;
    for (int k = 0; k < 6; k++) begin
      tick(); // grant cycle, completes immediately
      exp_addr = (k == LIMIT) ? 32'h100 : 32'h200;
      asserts++; if (ramREN !== 1'b1 || ramaddr !== exp_addr) begin failures++; $display("FAIL starve_grant%0d: got ren %b addr %h required 1 %h", k, ramREN, ramaddr, exp_addr); end
      tick(); // back in IDLE
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_abort();
    dREN = 1; daddr = 32'h300; ramstate = BUSY;
    tick();
    asserts++; if (ramREN !== 1'b1 || ramaddr !== 32'h300) begin failures++; $display("FAIL abort_grant: got ren %b addr %h required 1 00000300", ramREN, ramaddr); end
    dREN = 0; #1;
    asserts++; if (dwait !== 1'b1) begin failures++; $display("FAIL abort_wait: got %b required 1", dwait); end
    tick();
    asserts++; if (ramREN !== 1'b0 || ramWEN !== 1'b0 || dwait !== 1'b1) begin failures++; $display("FAIL abort_idle: got ren %b wen %b dwait %b required 0 0 1", ramREN, ramWEN, dwait); end
    idle_inputs();
    tick();
  endtask

  task automatic test_error_retry();
    dWEN = 1; daddr = 32'h44; dstore = 32'hA5A50F0F; ramstate = BUSY;
    tick();
    ramstate = ERROR; #1;
    asserts++; if (ramWEN !== 1'b1 || dwait !== 1'b1) begin failures++; $display("FAIL err_wait: got wen %b dwait %b required 1 1", ramWEN, dwait); end
    tick();
    ramstate = BUSY; #1;
    asserts++; if (ramWEN !== 1'b0 || dwait !== 1'b1) begin failures++; $display("FAIL err_idle: got wen %b dwait %b required 0 1", ramWEN, dwait); end
    tick();
    asserts++; if (ramWEN !== 1'b1 || ramstore !== 32'hA5A50F0F) begin failures++; $display("FAIL err_regrant: got wen %b store %h required 1 a5a50f0f", ramWEN, ramstore); end
    ramstate = ACCESS; #1;
    asserts++; if (dwait !== 1'b0) begin failures++; $display("FAIL err_done: got dwait %b required 0", dwait); end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_grant();
    iREN = 1; iaddr = 32'h77; ramstate = BUSY;
    tick();
    asserts++; if (ramREN !== 1'b1) begin failures++; $display("FAIL rst_pre: got ren %b required 1", ramREN); end
    #1 nRST = 0;
    ramstate = ACCESS; #1;
    asserts++; if (ramREN !== 1'b0 || iwait !== 1'b1) begin failures++; $display("FAIL rst_async: got ren %b iwait %b required 0 1", ramREN, iwait); end
    tick();
    nRST = 1; ramstate = BUSY; #1;
    asserts++; if (ramREN !== 1'b0 || iwait !== 1'b1) begin failures++; $display("FAIL rst_release: got ren %b iwait %b required 0 1", ramREN, iwait); end
    tick();
    asserts++; if (ramREN !== 1'b1 || ramaddr !== 32'h77) begin failures++; $display("FAIL rst_regrant: got ren %b addr %h required 1 00000077", ramREN, ramaddr); end
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(3) == 0) iREN = ~iREN;
      if ($urandom_range(3) == 0) dREN = ~dREN;
      if ($urandom_range(5) == 0) dWEN = ~dWEN;
      iaddr    = $urandom;
      daddr    = $urandom;
      dstore   = $urandom;
      ramload  = $urandom;
      ramstate = ramstate_t'($urandom_range(3));
      #1;
      model_eval();
      asserts++;
      if ({ramREN, ramWEN, iwait, dwait} !== {e_ren, e_wen, e_iwait, e_dwait}) begin
        failures++; $display("FAIL rnd_ctrl c%0d: got ren/wen/iw/dw %b required %b", c,
                             {ramREN, ramWEN, iwait, dwait}, {e_ren, e_wen, e_iwait, e_dwait});
      end
      asserts++;
      if (ramaddr !== e_addr || ramstore !== e_store) begin
        failures++; $display("FAIL rnd_bus c%0d: got addr %h store %h required %h %h", c, ramaddr, ramstore, e_addr, e_store);
      end
      asserts++;
      if (iload !== e_iload || dload !== e_dload) begin
        failures++; $display("FAIL rnd_load c%0d: got iload %h dload %h required %h %h", c, iload, dload, e_iload, e_dload);
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    nRST = 0;
    test_reset();
    test_ifetch();
    test_priority();
    test_starvation();
    test_abort();
    test_error_retry();
    test_reset_mid_grant();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: the number of consecutive dcache completions allowed while iREN is held before icache is forced a grant.
REQ-002 CLK  in  1  system clock; all state updates on the rising edge.
REQ-003 nRST  in  1  asynchronous, active-low reset.
REQ-004 iREN  in  1  icache read request.
REQ-005 iaddr  in  32  icache word address (word_t).
REQ-006 iwait  out  1  low exactly in the cycle the icache read completes.
REQ-007 iload  out  32  icache read data; equals ramload when iwait is low, else 0.
REQ-008 dREN  in  1  dcache read request.
REQ-009 dWEN  in  1  dcache write request.
REQ-010 daddr  in  32  dcache word address.
REQ-011 dstore  in  32  dcache write data.
REQ-012 dwait  out  1  low exactly in the cycle the dcache access completes.
REQ-013 dload  out  32  dcache read data; equals ramload when dwait is low in DREAD, else 0.
REQ-014 ramREN  out  1  RAM read enable.
REQ-015 ramWEN  out  1  RAM write enable.
REQ-016 ramaddr  out  32  RAM address.
REQ-017 ramstore  out  32  RAM write data.
REQ-018 ramload  in  32  RAM read data.
REQ-019 ramstate  in  2  RAM status, ramstate_t: FREE, BUSY, ACCESS, ERROR.

Function
REQ-020 The arbiter SHALL be an FSM with four states: IDLE, IFETCH, DREAD, DWRITE.
REQ-021 In IDLE, all RAM enables SHALL be low, both waits SHALL be high, and ramaddr and ramstore SHALL be 0.
REQ-022 IDLE SHALL choose the next state with this priority: starvation flag with iREN -> IFETCH; dWEN -> DWRITE; dREN -> DREAD; iREN -> IFETCH; otherwise stay in IDLE.
REQ-023 When dREN and dWEN are both high, DWRITE SHALL win.
REQ-024 Arbitration latency SHALL be one cycle: a request seen in IDLE drives the RAM starting the next cycle.
REQ-025 IFETCH SHALL drive ramREN=1 and ramaddr=iaddr.
REQ-026 DREAD SHALL drive ramREN=1 and ramaddr=daddr.
REQ-027 DWRITE SHALL drive ramWEN=1, ramaddr=daddr and ramstore=dstore.
REQ-028 In a grant state, when ramstate==ACCESS, the granted wait SHALL go low combinationally that cycle, and the FSM SHALL return to IDLE.
REQ-029 With ramstate BUSY or FREE, the FSM SHALL hold the grant state and keep the wait high.
REQ-030 With ramstate ERROR, the FSM SHALL return to IDLE with the wait held high, so the request is re-arbitrated (retry).
REQ-031 If the granted requester deasserts its request mid-grant (IFETCH: iREN low; DREAD: dREN low; DWRITE: dWEN low), the FSM SHALL abort to IDLE the next cycle and drive both RAM enables low in that cycle.
REQ-032 The non-granted wait SHALL remain high at all times.
REQ-033 A 3-bit saturating counter SHALL increment on each dcache completion while iREN is high.
REQ-034 The counter SHALL clear on any icache completion or whenever iREN is low.
REQ-035 The starvation flag SHALL be counter >= STARVE_LIMIT.
REQ-036 A completion cycle SHALL always return to IDLE; back-to-back grants are therefore separated by exactly one IDLE cycle.

Reset
REQ-037 While nRST is low, the state SHALL be IDLE and the counter 0.
REQ-038 During reset, iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iload=0 and dload=0.
REQ-039 Reset asserted mid-grant SHALL drop RAM enables immediately, with no completion signalled.

Structure
REQ-040 word_t and ramstate_t SHALL come from cpu_types_pkg.
REQ-041 The arbiter state enum arb_state_t SHALL be added to cpu_types_pkg.
REQ-042 The block SHALL be a single module with no sub-modules; the starvation counter is inline.

Verification
REQ-043 iREN=1, iaddr=0x40; ramstate BUSY 2 cycles then ACCESS with ramload=0xDEADBEEF -> IFETCH at cycle 1; iwait low for exactly 1 cycle with iload=0xDEADBEEF; dwait high throughout.
REQ-044 iREN, dREN and dWEN all high in the same cycle, daddr=0x80, dstore=0x12345678 -> DWRITE granted; ramWEN=1, ramaddr=0x80, ramstore=0x12345678; icache waits.
REQ-045 dREN pulsed continuously with iREN held high and STARVE_LIMIT=4 -> after 4 dcache completions, the next grant is IFETCH; the counter returns to 0.
REQ-046 DREAD granted, then dREN dropped before ACCESS -> next cycle IDLE, ramREN=0, dwait stays high.
REQ-047 DWRITE granted; ramstate=ERROR -> IDLE with dwait high, then a re-grant of DWRITE 1 cycle later.
REQ-048 nRST pulsed low during IFETCH -> ramREN=0 asynchronously; iwait=1; state IDLE after release.
